fpu_normalize: RTL and testbench
================================

Name: fpu_normalize

Overview:
- Downstream normalise/pack stage for the single-precision FPU datapath.
- Consumes a raw sign, a wide signed exponent and an unnormalised mantissa (carry bit plus leading zeros) from the add/sub/mul/div stage.
- Iteratively shifts the mantissa to 1.xxx form, range-checks the exponent, and emits a packed IEEE 754 word.
- Uses a valid/ready handshake on both sides; one transaction in flight.

Parameters:
- EXP_W, 10: input exponent width, two's-complement signed, biased by 127.
- MAN_W, 25: input mantissa width. Bit 24 is the carry, bit 23 is the hidden one, bits 22:0 are the fraction.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  raw operand present
- in_ready  out  1  block can accept; equals (state==IDLE)
- in_sign  in  1  raw sign
- in_exponent  in  EXP_W  signed biased exponent
- in_mantissa  in  MAN_W  unnormalised mantissa
- out_valid  out  1  outp valid
- out_ready  in  1  consumer accepts
- outp  out  32  packed IEEE 754 result
- out_ovf  out  1  result saturated to infinity
- out_unf  out  1  result flushed or denormalised

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, outp=0, out_ovf=0, out_unf=0, internal registers 0. A transaction in flight is dropped. in_ready goes high on the first edge after release.
- States: IDLE, NORM, DONE.
- IDLE:
  - On in_valid&in_ready, load sign/exp/mant registers and go to NORM.
- NORM: one decision per cycle, evaluated in priority order.
  1. mant==0: outp={sign,31'b0}; out_ovf=0, out_unf=0; go to DONE.
  2. mant[24]=1: mant>>=1 (bit 0 truncated), exp+=1; stay in NORM.
  3. mant[23]=1: pack and go to DONE.
     - exp>=255: outp={sign,8'hFF,23'b0}, out_ovf=1.
     - exp<=0: outp={sign,31'b0}, out_unf=1.
     - otherwise: outp={sign,exp[7:0],mant[22:0]}.
  4. Otherwise: mant<<=1, exp-=1; stay in NORM.
     - Early exit: if exp is already <=0 before the shift, flush to signed zero with out_unf=1 and go to DONE.
- DONE:
  - out_valid=1; outp and flags held stable.
  - On out_ready go to IDLE, clearing out_valid on the same edge.
  - No new input is accepted while in DONE.
- Latency, accept edge to out_valid edge:
  - Already-normal input: 1 cycle.
  - Carry input: 2 cycles.
  - Each leading zero adds 1 cycle.
  - Worst case is mant=1: 24 cycles.
- Arithmetic:
  - exp increments and decrements use EXP_W-bit signed arithmetic.
  - Inputs are bounded so exp never wraps, in the range -512..511.
- No NaN or infinity input semantics: in_exponent=255 with a normal mantissa yields infinity with out_ovf=1.
- Simultaneous in_valid and DONE-state out_ready: input is not accepted that cycle, because in_ready=0.

Optional Feature:
- Macro: FPU_NORM_SUBNORM_EN.
- Defined (gradual underflow):
  - In NORM, if exp==1 and mant[23]=0 and mant!=0: stop shifting and emit outp={sign,8'h00,mant[22:0]}, out_unf=1.
  - At NORM entry with mant[23]=1 and exp<=0: mant>>=1, exp+=1 per cycle until exp==1, then emit exponent field 0.
  - If the mantissa shifts out to zero, emit signed zero.
- Undefined: flush-to-zero as described under Behaviour.

Decomposition:
- Package fpu_pkg:
  - Constants FP_BIAS=127, FP_EXP_MAX=255, FP_FRAC_W=23.
  - State enum typedef norm_state_t {IDLE,NORM,DONE}.
  - Packed typedef fp32_t {sign, exp[7:0], frac[22:0]}.
- Sub-module fpu_norm_pack: combinational range check and packing (sign, exp, mant in; outp, ovf, unf out), instantiated once in NORM's pack path.

Test Plan:
- Normal: sign=0, exp=130, mant=0x0C00000 -> outp=0x41400000, flags 0, out_valid 1 cycle after accept.
- Carry: sign=0, exp=127, mant=0x1800000 -> outp=0x40400000, latency 2.
- Max left shift: exp=150, mant=0x0000001 -> outp=0x3F800000, latency 24. Zero input: sign=1, mant=0 -> outp=0x80000000.
- Overflow: exp=300, mant=0x0800000 -> outp=0x7F800000, out_ovf=1.
- Underflow: exp=10, mant=0x0000001.
  - Macro undefined: outp=0x00000000, out_unf=1.
  - Macro defined: 9 left shifts, outp=0x00000200, out_unf=1.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> outp stable, in_ready=0. Assert rst_n=0 mid-NORM -> out_valid=0 immediately; after release, the next transaction completes correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants, state encoding and IEEE 754 word layout for the FPU
// normalise/pack stage.
package fpu_pkg;

  localparam int unsigned FP_BIAS    = 127;
  localparam int unsigned FP_EXP_MAX = 255;
  localparam int unsigned FP_FRAC_W  = 23;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } norm_state_t;

  typedef struct packed {
    logic                 sign;
    logic [7:0]           exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fpu_norm_pack.sv
// Combinational exponent range check and IEEE 754 packing of a normalised
// mantissa: saturates to infinity or flushes to signed zero out of range.
module fpu_norm_pack
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 10
) (
  input  logic                    sign_i,
  input  logic signed [EXP_W-1:0] exp_i,
  input  logic [FP_FRAC_W-1:0]    frac_i,
  output fp32_t                   word_c,
  output logic                    ovf_c,
  output logic                    unf_c
);

  localparam logic signed [EXP_W-1:0] EXP_SAT  = EXP_W'(FP_EXP_MAX);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);

  always_comb begin
    word_c      = '0;
    word_c.sign = sign_i;
    ovf_c       = 1'b0;
    unf_c       = 1'b0;
    if (exp_i >= EXP_SAT) begin
      word_c.exp = 8'hFF;
      ovf_c      = 1'b1;
    end else if (exp_i <= EXP_ZERO) begin
      unf_c = 1'b1;
    end else begin
      word_c.exp  = exp_i[7:0];
      word_c.frac = frac_i;
    end
  end

endmodule

// File: rtl/fpu_normalize.sv
// Iterative normalise/pack stage: one shift decision per cycle, then a packed
// IEEE 754 word. Define FPU_NORM_SUBNORM_EN for gradual underflow.
module fpu_normalize
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 10,
  parameter int unsigned MAN_W = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exponent,
  input  logic [MAN_W-1:0]        in_mantissa,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             outp,
  output logic                    out_ovf,
  output logic                    out_unf
);

  localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);
  localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  norm_state_t              state_q, state_d;
  logic                     live_q;
  logic                     sign_q, sign_d;
  logic signed [EXP_W-1:0]  exp_q, exp_d;
  logic [MAN_W-1:0]         mant_q, mant_d;
  fp32_t                    word_q, word_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     valid_q, valid_d;
`ifdef FPU_NORM_SUBNORM_EN
  logic                     denorm_q, denorm_d;
`endif

  fp32_t pack_word_c;
  logic  pack_ovf_c;
  logic  pack_unf_c;

  fpu_norm_pack #(
    .EXP_W (EXP_W)
  ) u_pack (
    .sign_i (sign_q),
    .exp_i  (exp_q),
    .frac_i (mant_q[FP_FRAC_W-1:0]),
    .word_c (pack_word_c),
    .ovf_c  (pack_ovf_c),
    .unf_c  (pack_unf_c)
  );

  // in_ready stays low until the first edge after reset release.
  assign in_ready  = (state_q == IDLE) && live_q;
  assign out_valid = valid_q;
  assign outp      = word_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    word_d  = word_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    valid_d = valid_q;
`ifdef FPU_NORM_SUBNORM_EN
    denorm_d = denorm_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d  = in_sign;
          exp_d   = in_exponent;
          mant_d  = in_mantissa;
          state_d = NORM;
`ifdef FPU_NORM_SUBNORM_EN
          denorm_d = 1'b0;
`endif
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          word_d  = '{sign: sign_q, exp: 8'h00, frac: '0};
          ovf_d   = 1'b0;
`ifdef FPU_NORM_SUBNORM_EN
          unf_d   = denorm_q;
`else
          unf_d   = 1'b0;
`endif
          valid_d = 1'b1;
          state_d = DONE;
        end else if (mant_q[MAN_W-1]) begin
          mant_d = mant_q >> 1;
          exp_d  = exp_q + EXP_ONE;
`ifdef FPU_NORM_SUBNORM_EN
        end else if (exp_q <= EXP_ZERO) begin
          // Denormalise towards exponent 1; low bits are truncated.
          mant_d   = mant_q >> 1;
          exp_d    = exp_q + EXP_ONE;
          denorm_d = 1'b1;
        end else if (mant_q[MAN_W-2]) begin
          word_d  = pack_word_c;
          ovf_d   = pack_ovf_c;
          unf_d   = pack_unf_c;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (exp_q == EXP_ONE) begin
          word_d  = '{sign: sign_q, exp: 8'h00, frac: mant_q[FP_FRAC_W-1:0]};
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
`else
        end else if (mant_q[MAN_W-2]) begin
          word_d  = pack_word_c;
          ovf_d   = pack_ovf_c;
          unf_d   = pack_unf_c;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (exp_q <= EXP_ZERO) begin
          word_d  = '{sign: sign_q, exp: 8'h00, frac: '0};
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
`endif
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef FPU_NORM_SUBNORM_EN
      denorm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      valid_q <= valid_d;
`ifdef FPU_NORM_SUBNORM_EN
      denorm_q <= denorm_d;
`endif
    end
  end

endmodule

// File: tb/tb_fpu_normalize.sv
// Self-checking bench for fpu_normalize: directed vectors, randomized
// operands against a value-level model, backpressure and reset cases.
module tb_fpu_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exponent;
  logic [24:0] in_mantissa;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] outp;
  logic        out_ovf;
  logic        out_unf;

  int total = 0;
  int bad   = 0;

  fpu_normalize dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exponent (in_exponent),
    .in_mantissa (in_mantissa),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .outp        (outp),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf)
  );

  always #5 clk = ~clk;

  // Value-level reference: locate the leading one, derive the final
  // exponent directly, and count cycles from the number of shifts needed.
  function automatic void model(input logic s, input int e, input int m,
                                output logic [31:0] w, output logic ovf,
                                output logic unf, output int lat);
    int p, en, f, fr;
    ovf = 1'b0; unf = 1'b0; w = {s, 31'b0}; lat = 1;
    if (m == 0) return;
    p = 0;
    for (int i = 0; i < 25; i++) if (m[i]) p = i;
    en  = e + p - 23;
    lat = (p == 24) ? 2 : 1 + (23 - p);
`ifdef FPU_NORM_SUBNORM_EN
    if (en < 1) begin
      unf = 1'b1;
      if (e >= 1) begin
        f = m << (e - 1);
        lat = e;
      end else begin
        f = m >> (1 - e);
        lat = (((1 - e) < (p + 1)) ? (1 - e) : (p + 1)) + 1;
      end
      w = {s, 8'h00, f[22:0]};
      return;
    end
`else
    if (p < 23 && e < 23 - p) begin
      unf = 1'b1;
      lat = ((e > 0) ? e : 0) + 1;
      return;
    end
    if (en <= 0) begin
      unf = 1'b1;
      return;
    end
`endif
    if (en >= 255) begin
      ovf = 1'b1;
      w = {s, 8'hFF, 23'h0};
      return;
    end
    fr = (p == 24) ? (m >> 1) : (m << (23 - p));
    w = {s, en[7:0], fr[22:0]};
  endfunction

  task automatic send(input logic s, input int e, input logic [24:0] m,
                      output logic [31:0] w, output logic ovf, output logic unf,
                      output int lat);
    int wait_c;
    in_sign = s; in_exponent = 10'(e); in_mantissa = m; in_valid = 1'b1;
    wait_c = 0;
    while (!in_ready && wait_c < 50) begin
      @(posedge clk); #1; wait_c++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    w = outp; ovf = out_ovf; unf = out_unf;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if ({outp, out_ovf, out_unf} !== 34'h0) begin bad++; $display("FAIL rst_outputs got=%h/%b/%b exp=0", outp, out_ovf, out_unf); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_release_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_first_edge_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] w; logic ovf, unf; int lat;
    logic [31:0] unf_w; int unf_lat;
    send(1'b0, 130, 25'h0C00000, w, ovf, unf, lat);
    total++; if ({w, ovf, unf} !== {32'h41400000, 2'b00}) begin bad++; $display("FAIL normal got=%h/%b%b exp=41400000/00", w, ovf, unf); end
    total++; if (lat !== 1) begin bad++; $display("FAIL normal_lat got=%0d exp=1", lat); end
    release_out();
    send(1'b0, 127, 25'h1800000, w, ovf, unf, lat);
    total++; if ({w, ovf, unf} !== {32'h40400000, 2'b00}) begin bad++; $display("FAIL carry got=%h/%b%b exp=40400000/00", w, ovf, unf); end
    total++; if (lat !== 2) begin bad++; $display("FAIL carry_lat got=%0d exp=2", lat); end
    release_out();
    send(1'b0, 150, 25'h0000001, w, ovf, unf, lat);
    total++; if ({w, ovf, unf} !== {32'h3F800000, 2'b00}) begin bad++; $display("FAIL maxshift got=%h/%b%b exp=3F800000/00", w, ovf, unf); end
    total++; if (lat !== 24) begin bad++; $display("FAIL maxshift_lat got=%0d exp=24", lat); end
    release_out();
    send(1'b1, 77, 25'h0000000, w, ovf, unf, lat);
    total++; if ({w, ovf, unf} !== {32'h80000000, 2'b00}) begin bad++; $display("FAIL zero got=%h/%b%b exp=80000000/00", w, ovf, unf); end
    release_out();
    send(1'b0, 300, 25'h0800000, w, ovf, unf, lat);
    total++; if ({w, ovf, unf} !== {32'h7F800000, 2'b10}) begin bad++; $display("FAIL overflow got=%h/%b%b exp=7F800000/10", w, ovf, unf); end
    release_out();
    send(1'b0, 255, 25'h0A00000, w, ovf, unf, lat);
    total++; if ({w, ovf, unf} !== {32'h7F800000, 2'b10}) begin bad++; $display("FAIL exp255 got=%h/%b%b exp=7F800000/10", w, ovf, unf); end
    release_out();
`ifdef FPU_NORM_SUBNORM_EN
    unf_w = 32'h00000200; unf_lat = 10;
`else
    unf_w = 32'h00000000; unf_lat = 11;
`endif
    send(1'b0, 10, 25'h0000001, w, ovf, unf, lat);
    total++; if ({w, ovf, unf} !== {unf_w, 2'b01}) begin bad++; $display("FAIL underflow got=%h/%b%b exp=%h/01", w, ovf, unf, unf_w); end
    total++; if (lat !== unf_lat) begin bad++; $display("FAIL underflow_lat got=%0d exp=%0d", lat, unf_lat); end
    release_out();
  endtask

  task automatic test_random();
    logic [31:0] w, ew; logic ovf, unf, eovf, eunf; int lat, elat;
    int p, e, m; logic s;
    for (int n = 0; n < 60; n++) begin
      p = $urandom_range(0, 25);
      if (p == 25) m = 0;
      else m = (1 << p) | (int'($urandom) & ((1 << p) - 1));
      e = (n % 2 == 0) ? ($urandom_range(0, 600) - 300) : ($urandom_range(0, 60) - 30);
      s = 1'($urandom);
      model(s, e, m, ew, eovf, eunf, elat);
      send(s, e, 25'(m), w, ovf, unf, lat);
      total++;
      if ({w, ovf, unf} !== {ew, eovf, eunf} || lat !== elat) begin
        bad++;
        $display("FAIL random s=%b e=%0d m=%h got=%h/%b%b lat=%0d exp=%h/%b%b lat=%0d",
                 s, e, m, w, ovf, unf, lat, ew, eovf, eunf, elat);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w; logic ovf, unf; int lat;
    send(1'b1, 129, 25'h0E00000, w, ovf, unf, lat);
    in_sign = 1'b0; in_exponent = 10'd140; in_mantissa = 25'h0800000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (outp !== 32'hC0E00000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure cyc=%0d got=%h v=%b rdy=%b exp=C0E00000 v=1 rdy=0", i, outp, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    release_out();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    send(1'b0, 126, 25'h0900000, w, ovf, unf, lat);
    total++; if ({w, ovf, unf} !== {32'h3F100000, 2'b00}) begin bad++; $display("FAIL bp_next got=%h/%b%b exp=3F100000/00", w, ovf, unf); end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w; logic ovf, unf; int lat;
    in_sign = 1'b0; in_exponent = 10'd150; in_mantissa = 25'h0000001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_norm got v=%b rdy=%b exp 0/0", out_valid, in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 131, 25'h0A00000, w, ovf, unf, lat);
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || outp !== 32'h0) begin bad++; $display("FAIL rst_in_done got v=%b outp=%h exp 0/0", out_valid, outp); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b1, 140, 25'h1000000, w, ovf, unf, lat);
    total++; if ({w, ovf, unf} !== {32'hC6800000, 2'b00} || lat !== 2) begin bad++; $display("FAIL rst_recover got=%h/%b%b lat=%0d exp=C6800000/00 lat=2", w, ovf, unf, lat); end
    release_out();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exponent = '0;
    in_mantissa = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
